// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, FSM states and opcode check.
package alu_pkg;

    localparam logic [2:0] OP_SUMA  = 3'b001;
    localparam logic [2:0] OP_RESTA = 3'b010;
    localparam logic [2:0] OP_AND   = 3'b011;
    localparam logic [2:0] OP_OR    = 3'b100;

    typedef enum logic [2:0] {
        ESPERA_A,
        ESPERA_B,
        ESPERA_OP,
        EJECUTA,
        ENTREGA
    } estado_t;

    function automatic logic op_valida(input logic [2:0] op);
        return (op == OP_SUMA) || (op == OP_RESTA) || (op == OP_AND) || (op == OP_OR);
    endfunction

endpackage

// File: rtl/alu_secuenciador.sv
// Sequences an external n_bits ALU: collects A, B and opcode, captures the result
// and hands it off with status flags over a valid/ready channel.
module alu_secuenciador
    import alu_pkg::*;
#(
    parameter int unsigned n_bits = 8,
    parameter int unsigned n_cont = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [n_bits-1:0] in_dato,
    input  logic              in_encadenar,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [n_bits-1:0] alu_a,
    output logic [n_bits-1:0] alu_b,
    output logic [2:0]        alu_op,
    input  logic [n_bits-1:0] alu_resultado,
    output logic [n_bits-1:0] res_dato,
    output logic              res_cero,
    output logic              res_negativo,
    output logic              res_error,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [n_cont-1:0] ops_hechas
);

    estado_t           estado_q, estado_d;
    logic [n_bits-1:0] a_q, a_d;
    logic [n_bits-1:0] b_q, b_d;
    logic [2:0]        op_q, op_d;
    logic [n_bits-1:0] ultimo_q, ultimo_d;
    logic [n_bits-1:0] res_dato_q, res_dato_d;
    logic              res_cero_q, res_cero_d;
    logic              res_negativo_q, res_negativo_d;
    logic              res_error_q, res_error_d;
    logic              res_valid_q, res_valid_d;
    logic              in_ready_q, in_ready_d;
    logic [n_cont-1:0] ops_q, ops_d;

    logic acepta;
    assign acepta = in_valid && in_ready_q;

    always_comb begin
        estado_d       = estado_q;
        a_d            = a_q;
        b_d            = b_q;
        op_d           = op_q;
        ultimo_d       = ultimo_q;
        res_dato_d     = res_dato_q;
        res_cero_d     = res_cero_q;
        res_negativo_d = res_negativo_q;
        res_error_d    = res_error_q;
        ops_d          = ops_q;

        case (estado_q)
            ESPERA_A: if (acepta) begin
                a_d      = in_encadenar ? ultimo_q : in_dato;
                estado_d = ESPERA_B;
            end
            ESPERA_B: if (acepta) begin
                b_d      = in_dato;
                estado_d = ESPERA_OP;
            end
            ESPERA_OP: if (acepta) begin
                op_d     = in_dato[2:0];
                estado_d = EJECUTA;
            end
            EJECUTA: begin
                res_dato_d     = alu_resultado;
                res_cero_d     = (alu_resultado == '0);
                res_negativo_d = alu_resultado[n_bits-1];
                res_error_d    = !op_valida(op_q);
                ultimo_d       = alu_resultado;
                estado_d       = ENTREGA;
            end
            ENTREGA: if (res_ready) begin
                ops_d    = ops_q + n_cont'(1);
                estado_d = ESPERA_A;
            end
            default: estado_d = ESPERA_A;
        endcase

        // Handshake outputs are registered, so derive them from the next state.
        in_ready_d  = (estado_d == ESPERA_A) || (estado_d == ESPERA_B) || (estado_d == ESPERA_OP);
        res_valid_d = (estado_d == ENTREGA);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q       <= ESPERA_A;
            a_q            <= '0;
            b_q            <= '0;
            op_q           <= '0;
            ultimo_q       <= '0;
            res_dato_q     <= '0;
            res_cero_q     <= 1'b0;
            res_negativo_q <= 1'b0;
            res_error_q    <= 1'b0;
            res_valid_q    <= 1'b0;
            in_ready_q     <= 1'b0;
            ops_q          <= '0;
        end else begin
            estado_q       <= estado_d;
            a_q            <= a_d;
            b_q            <= b_d;
            op_q           <= op_d;
            ultimo_q       <= ultimo_d;
            res_dato_q     <= res_dato_d;
            res_cero_q     <= res_cero_d;
            res_negativo_q <= res_negativo_d;
            res_error_q    <= res_error_d;
            res_valid_q    <= res_valid_d;
            in_ready_q     <= in_ready_d;
            ops_q          <= ops_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign alu_op       = op_q;
    assign res_dato     = res_dato_q;
    assign res_cero     = res_cero_q;
    assign res_negativo = res_negativo_q;
    assign res_error    = res_error_q;
    assign res_valid    = res_valid_q;
    assign ops_hechas   = ops_q;

endmodule

// File: tb/tb_alu_secuenciador.sv
// Bench for alu_secuenciador: behavioural ALU, transaction-level scoreboard and directed tests.
module tb_alu_secuenciador;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_dato;
    logic       in_encadenar;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] alu_a, alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_resultado;
    logic [7:0] res_dato;
    logic       res_cero, res_negativo, res_error, res_valid;
    logic       res_ready;
    logic [7:0] ops_hechas;

    int checks = 0;
    int failures = 0;

    alu_secuenciador #(.n_bits(8), .n_cont(8)) dut (
        .clk(clk), .reset(reset),
        .in_dato(in_dato), .in_encadenar(in_encadenar), .in_valid(in_valid), .in_ready(in_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_resultado(alu_resultado),
        .res_dato(res_dato), .res_cero(res_cero), .res_negativo(res_negativo),
        .res_error(res_error), .res_valid(res_valid), .res_ready(res_ready),
        .ops_hechas(ops_hechas)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd1:    return a + b;
            3'd2:    return a - b;
            3'd3:    return a & b;
            3'd4:    return a | b;
            default: return 8'h00;
        endcase
    endfunction

    // Stand-in for the team ALU.
    assign alu_resultado = alu_f(alu_op, alu_a, alu_b);

    typedef struct packed {
        logic [7:0] dato;
        logic       err;
    } exp_t;

    exp_t       m_q[$];
    logic [7:0] m_last = 8'h00;
    logic [7:0] m_count = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_last  = 8'h00;
        m_count = 8'h00;
    endtask

    // Scoreboard: counter every cycle, result/flags whenever a result is offered.
    always @(negedge clk) begin
        if (!reset) begin
            chk("ops_hechas", 32'(ops_hechas), 32'(m_count));
            if (res_valid) begin
                if (m_q.size() == 0) begin
                    chk("unexpected_res_valid", 32'(res_valid), 32'd0);
                end else begin
                    chk("sb_res_dato", 32'(res_dato), 32'(m_q[0].dato));
                    chk("sb_res_cero", 32'(res_cero), 32'(m_q[0].dato == 8'h00));
                    chk("sb_res_negativo", 32'(res_negativo), 32'(m_q[0].dato[7]));
                    chk("sb_res_error", 32'(res_error), 32'(m_q[0].err));
                    if (res_ready) begin
                        void'(m_q.pop_front());
                        m_count = m_count + 8'd1;
                    end
                end
            end
        end
    end

    task automatic put_word(input logic [7:0] d, input logic ch);
        int n = 0;
        in_dato      = d;
        in_encadenar = ch;
        in_valid     = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid     = 1'b0;
        in_encadenar = 1'b0;
    endtask

    task automatic send(input logic [7:0] a, input logic ch, input logic [7:0] b, input logic [2:0] op);
        logic [7:0] ea;
        logic [7:0] r;
        ea = ch ? m_last : a;
        r  = alu_f(op, ea, b);
        m_last = r;
        m_q.push_back('{dato: r, err: (op == 3'd0 || op > 3'd4)});
        put_word(a, ch);
        put_word(b, 1'b1);
        put_word({5'b10101, op}, 1'b0);
    endtask

    task automatic wait_valid();
        int n = 0;
        @(negedge clk);
        while (!res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!res_valid) chk("res_valid_timeout", 32'(res_valid), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_res_dato"}, 32'(res_dato), 32'd0);
        chk({tag, "_res_flags"}, 32'({res_cero, res_negativo, res_error}), 32'd0);
        chk({tag, "_alu_ab"}, 32'({alu_a, alu_b}), 32'd0);
        chk({tag, "_alu_op"}, 32'(alu_op), 32'd0);
        chk({tag, "_ops_hechas"}, 32'(ops_hechas), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; res_ready = 1'b1; in_valid = 1'b0; in_dato = 8'h00; in_encadenar = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;

        // Suma with latency check
        send(8'h05, 1'b0, 8'h03, 3'b001);
        chk("t1_valid_after_accept", 32'(res_valid), 32'd0);
        chk("t1_in_ready_exec", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        chk("t1_latency_valid", 32'(res_valid), 32'd1);
        chk("t1_res_dato", 32'(res_dato), 32'h08);
        chk("t1_flags", 32'({res_cero, res_negativo, res_error}), 32'd0);
        @(posedge clk); #1;
        chk("t1_ops", 32'(ops_hechas), 32'd1);
        chk("t1_valid_drop", 32'(res_valid), 32'd0);
        chk("t1_res_retained", 32'(res_dato), 32'h08);

        // Resta, then chaining (0xAA must be ignored)
        send(8'h03, 1'b0, 8'h05, 3'b010);
        wait_valid();
        chk("t2_resta", 32'(res_dato), 32'hFE);
        chk("t2_negativo", 32'(res_negativo), 32'd1);
        send(8'hAA, 1'b1, 8'h0F, 3'b011);
        wait_valid();
        chk("t2_chain_a", 32'(alu_a), 32'hFE);
        chk("t2_chain_and", 32'(res_dato), 32'h0E);

        // Invalid opcode
        send(8'h12, 1'b0, 8'h34, 3'b111);
        wait_valid();
        chk("t3_dato", 32'(res_dato), 32'h00);
        chk("t3_cero_err", 32'({res_cero, res_error}), 32'b11);
        @(posedge clk); #1;
        chk("t3_ops", 32'(ops_hechas), 32'd4);

        // Backpressure
        res_ready = 1'b0;
        send(8'h40, 1'b0, 8'h41, 3'b100);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            in_dato  = 8'hFF;
            in_valid = (i % 2 == 0);
            chk("t4_in_ready", 32'(in_ready), 32'd0);
            chk("t4_res_valid", 32'(res_valid), 32'd1);
            chk("t4_res_dato", 32'(res_dato), 32'h41);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        chk("t4_ops_after", 32'(ops_hechas), 32'd5);
        chk("t4_valid_drop", 32'(res_valid), 32'd0);
        @(posedge clk); #1;
        chk("t4_single_handoff", 32'(ops_hechas), 32'd5);

        // Reset while waiting for the opcode
        put_word(8'h10, 1'b0);
        put_word(8'h20, 1'b0);
        #2 reset = 1'b1;
        model_reset();
        #1;
        check_all_zero("t5");
        @(posedge clk); #3 reset = 1'b0;
        send(8'h55, 1'b1, 8'h07, 3'b100);
        wait_valid();
        chk("t5_chain_a_zero", 32'(alu_a), 32'h00);
        chk("t5_res", 32'(res_dato), 32'h07);
        @(posedge clk); #1;
        chk("t5_ops", 32'(ops_hechas), 32'd1);

        // Counter wrap after 256 operations
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(posedge clk); #3 reset = 1'b0;
        for (int i = 0; i < 256; i++) send(8'(i), 1'b0, 8'h0F, 3'b100);
        wait_valid();
        @(posedge clk); #1;
        chk("t6_wrap", 32'(ops_hechas), 32'd0);
        chk("t6_last", 32'(res_dato), 32'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
